primitive_assembler: RTL and testbench
======================================

// Module: primitive_assembler
// PURPOSE
//  Sink for the transformed-vertex stream produced by the vertex processor: accepts signed M-bit
//  components (x,y,z,w per vertex, one per beat), groups vertices into triangles (list or strip)
//  and presents one packed triangle per handshake to the rasterizer. Drops w; optional backface cull.
// PARAMETERS
//  M      11   component width (signed), equal to vertex-processor output width
//  CNT_W  16   width of triangle/cull statistics counters
// PORTS
//  clk            in   1      single clock, all logic rising-edge
//  rst_n          in   1      asynchronous, active-low reset
//  mode_strip     in   1      0 = triangle list, 1 = triangle strip; sampled only while mesh idle
//  in_data        in   M      signed vertex component, order x,y,z,w
//  in_valid       in   1      component valid
//  in_last        in   1      end of mesh; legal only on the w beat
//  in_ready       out  1      component accepted when in_valid & in_ready
//  out_tri        out  9*M    {z2,y2,x2,z1,y1,x1,z0,y0,x0}
//  out_valid      out  1      triangle valid
//  out_ready      in   1      triangle accepted when out_valid & out_ready
//  tri_count      out  CNT_W  triangles emitted since reset (wraps)
//  cull_count     out  CNT_W  triangles culled since reset (wraps)
//  proto_err      out  1      sticky: in_last seen on a non-w beat
// BEHAVIOUR
//  - Reset: in_ready=0 during reset, 1 the first cycle after; out_valid=0, out_tri=0,
//    counts=0, proto_err=0, FSM=FILL, comp_idx=0, vert_cnt=0, strip_par=0.
//  - FSM FILL: in_ready=1. Accepted beat stores into vertex reg v[vert_cnt] at comp_idx
//    (w discarded); comp_idx 0..3 wraps. On w beat vert_cnt++ (sat 3). When vert_cnt reaches 3
//    -> EVAL (in_ready=0 from the next cycle).
//  - EVAL (1 cycle): assemble triangle; strip with strip_par=1 swaps v1/v2 so winding is
//    consistent. Cull decision registered. -> HOLD if emitted, -> ADV if culled.
//  - HOLD: out_valid=1, out_tri stable until out_ready; on accept tri_count++ -> ADV.
//  - ADV (1 cycle): list: vert_cnt=0. strip: v0<=v1, v1<=v2, vert_cnt=2, strip_par toggles.
//    -> FILL. Latency: w beat of 3rd vertex accepted at cycle t -> out_valid at t+2.
//  - in_last on w beat: mesh ends after that vertex is processed; a complete triangle is still
//    emitted, then vert_cnt=0, strip_par=0. Incomplete triangle (1-2 verts) silently dropped.
//  - in_last on non-w beat: proto_err<=1, partial vertex and triangle discarded, comp_idx=0,
//    vert_cnt=0, strip_par=0; stream resumes at next beat as a new x.
//  - mode_strip latched when vert_cnt=0 and comp_idx=0 in FILL; changes mid-mesh ignored.
//  - Counters wrap at 2^CNT_W. No beats lost under any in_valid/out_ready pattern.
//  - Reset asserted mid-operation: all state cleared immediately, pending triangle lost.
// CONFIGURATION
//  BACKFACE_CULL_EN defined: in EVAL compute area=(x1-x0)*(y2-y0)-(x2-x0)*(y1-y0) on the
//    assembled (post-swap) triangle, signed width 2*M+3, no overflow; area<=0 -> culled,
//    cull_count++, no out_valid.
//  Not defined: no area logic, every triangle emitted, cull_count held at 0.
// TESTING
//  1 List, verts (0,0,1),(10,0,1),(0,10,1) w=256, out_ready=1 -> out_tri x0=0,x1=10,y2=10,
//    out_valid 2 cycles after 12th beat, tri_count=1.
//  2 Strip, 5 vertices -> 3 triangles; 2nd has v1/v2 swapped vs input order; tri_count=3.
//  3 out_ready held 0 for 20 cycles -> out_tri stable, in_ready=0, no beat lost on release.
//  4 in_last on y beat -> proto_err=1, following full triangle emitted correctly.
//  5 CULL_EN: CW triangle (0,0),(0,10),(10,0) -> no out_valid, cull_count=1; degenerate
//    (area 0) culled; CCW emitted. Without macro: all emitted, cull_count=0.
//  6 Random in_valid/out_ready, 1000 verts, scoreboard vs model incl. rst_n pulse mid-mesh.

Source files
------------

// File: rtl/primitive_assembler.sv
// ============================================================================
// primitive_assembler
// Groups a signed x,y,z,w component stream into list/strip triangles and
// hands one packed triangle per handshake to the rasterizer (w dropped).
// Optional feature macro: BACKFACE_CULL_EN (area<=0 triangles are culled).
// Revision: 1.0
// ============================================================================
`default_nettype none

module primitive_assembler #(
   parameter int M     = 11,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode_strip,
   input  logic [M-1:0]     in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [9*M-1:0]   out_tri,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] tri_count,
   output logic [CNT_W-1:0] cull_count,
   output logic             proto_err
);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_EVAL = 2'd1,
      S_HOLD = 2'd2,
      S_ADV  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [3*M-1:0]     v_q [3];
   logic [3*M-1:0]     v_d [3];
   logic [1:0]         comp_idx_q, comp_idx_d;
   logic [1:0]         vert_cnt_q, vert_cnt_d;
   logic               strip_par_q, strip_par_d;
   logic               strip_mode_q, strip_mode_d;
   logic               last_q, last_d;
   logic               in_ready_q, in_ready_d;
   logic [9*M-1:0]     out_tri_q, out_tri_d;
   logic [CNT_W-1:0]   tri_count_q, tri_count_d;
   logic [CNT_W-1:0]   cull_count_q, cull_count_d;
   logic               proto_err_q, proto_err_d;

   // Odd strip triangles swap v1/v2 so every triangle keeps the same winding
   logic               swap;
   logic [3*M-1:0]     tri_v1, tri_v2;
   logic [9*M-1:0]     tri_asm;
   logic               culled;

   always_comb begin
      swap    = strip_mode_q & strip_par_q;
      tri_v1  = swap ? v_q[2] : v_q[1];
      tri_v2  = swap ? v_q[1] : v_q[2];
      tri_asm = {tri_v2, tri_v1, v_q[0]};
   end

`ifdef BACKFACE_CULL_EN
   localparam int AW = 2*M+3;
   logic signed [M:0]      dx1, dy1, dx2, dy2;
   logic signed [2*M+1:0]  p0, p1;
   logic signed [AW-1:0]   area;

   always_comb begin
      dx1    = $signed({tri_v1[M-1], tri_v1[M-1:0]})   - $signed({v_q[0][M-1], v_q[0][M-1:0]});
      dx2    = $signed({tri_v2[M-1], tri_v2[M-1:0]})   - $signed({v_q[0][M-1], v_q[0][M-1:0]});
      dy1    = $signed({tri_v1[2*M-1], tri_v1[2*M-1:M]}) - $signed({v_q[0][2*M-1], v_q[0][2*M-1:M]});
      dy2    = $signed({tri_v2[2*M-1], tri_v2[2*M-1:M]}) - $signed({v_q[0][2*M-1], v_q[0][2*M-1:M]});
      p0     = dx1 * dy2;
      p1     = dx2 * dy1;
      area   = AW'(p0) - AW'(p1);
      culled = area[AW-1] | (area == '0);
   end
`else
   assign culled = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      v_d          = v_q;
      comp_idx_d   = comp_idx_q;
      vert_cnt_d   = vert_cnt_q;
      strip_par_d  = strip_par_q;
      strip_mode_d = strip_mode_q;
      last_d       = last_q;
      out_tri_d    = out_tri_q;
      tri_count_d  = tri_count_q;
      cull_count_d = cull_count_q;
      proto_err_d  = proto_err_q;

      case (state_q)
         S_FILL: begin
            if (vert_cnt_q == 2'd0 && comp_idx_q == 2'd0)
               strip_mode_d = mode_strip;
            if (in_valid && in_ready_q) begin
               if (in_last && comp_idx_q != 2'd3) begin
                  proto_err_d = 1'b1;
                  comp_idx_d  = 2'd0;
                  vert_cnt_d  = 2'd0;
                  strip_par_d = 1'b0;
               end else if (comp_idx_q != 2'd3) begin
                  for (int i = 0; i < 3; i++)
                     if (vert_cnt_q == 2'(i))
                        v_d[i][comp_idx_q*M +: M] = in_data;
                  comp_idx_d = comp_idx_q + 2'd1;
               end else begin
                  comp_idx_d = 2'd0;
                  if (vert_cnt_q == 2'd2) begin
                     vert_cnt_d = 2'd3;
                     last_d     = in_last;
                     state_d    = S_EVAL;
                  end else if (in_last) begin
                     // mesh ended before a triangle was complete
                     vert_cnt_d  = 2'd0;
                     strip_par_d = 1'b0;
                  end else begin
                     vert_cnt_d = vert_cnt_q + 2'd1;
                  end
               end
            end
         end
         S_EVAL: begin
            if (culled) begin
               cull_count_d = cull_count_q + CNT_W'(1);
               state_d      = S_ADV;
            end else begin
               out_tri_d = tri_asm;
               state_d   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               tri_count_d = tri_count_q + CNT_W'(1);
               state_d     = S_ADV;
            end
         end
         S_ADV: begin
            if (last_q) begin
               vert_cnt_d  = 2'd0;
               strip_par_d = 1'b0;
               last_d      = 1'b0;
            end else if (strip_mode_q) begin
               v_d[0]      = v_q[1];
               v_d[1]      = v_q[2];
               vert_cnt_d  = 2'd2;
               strip_par_d = ~strip_par_q;
            end else begin
               vert_cnt_d = 2'd0;
            end
            state_d = S_FILL;
         end
         default: state_d = S_FILL;
      endcase

      in_ready_d = (state_d == S_FILL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FILL;
         for (int i = 0; i < 3; i++)
            v_q[i] <= '0;
         comp_idx_q   <= 2'd0;
         vert_cnt_q   <= 2'd0;
         strip_par_q  <= 1'b0;
         strip_mode_q <= 1'b0;
         last_q       <= 1'b0;
         in_ready_q   <= 1'b0;
         out_tri_q    <= '0;
         tri_count_q  <= '0;
         cull_count_q <= '0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         for (int i = 0; i < 3; i++)
            v_q[i] <= v_d[i];
         comp_idx_q   <= comp_idx_d;
         vert_cnt_q   <= vert_cnt_d;
         strip_par_q  <= strip_par_d;
         strip_mode_q <= strip_mode_d;
         last_q       <= last_d;
         in_ready_q   <= in_ready_d;
         out_tri_q    <= out_tri_d;
         tri_count_q  <= tri_count_d;
         cull_count_q <= cull_count_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q == S_HOLD);
   assign out_tri    = out_tri_q;
   assign tri_count  = tri_count_q;
   assign cull_count = cull_count_q;
   assign proto_err  = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_primitive_assembler.sv
// ============================================================================
// tb_primitive_assembler
// Directed and randomized checks of primitive_assembler against a
// vertex-list reference model (honours BACKFACE_CULL_EN when defined).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_primitive_assembler;
   localparam int M     = 11;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             mode_strip = 1'b0;
   logic [M-1:0]     in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic [9*M-1:0]   out_tri;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [CNT_W-1:0] tri_count;
   logic [CNT_W-1:0] cull_count;
   logic             proto_err;

   primitive_assembler #(.M(M), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .mode_strip(mode_strip),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_tri(out_tri), .out_valid(out_valid), .out_ready(out_ready),
      .tri_count(tri_count), .cull_count(cull_count), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [9*M-1:0] act, input logic [9*M-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // reference model: vertices of the current mesh kept in order
   logic [3*M-1:0] mesh [$];
   logic [9*M-1:0] sb [$];
   logic [M-1:0]   part [3];
   int             m_idx = 0;
   bit             m_mode = 1'b0;
   int             m_emit = 0;
   int             m_cull = 0;
   bit             m_perr = 1'b0;
   bit             beat_acc;

   function automatic int sx(input logic [M-1:0] v);
      return int'($signed(v));
   endfunction

   task automatic make_tri(input logic [3*M-1:0] a, input logic [3*M-1:0] b, input logic [3*M-1:0] c);
`ifdef BACKFACE_CULL_EN
      int area;
      area = (sx(b[M-1:0]) - sx(a[M-1:0])) * (sx(c[2*M-1:M]) - sx(a[2*M-1:M]))
           - (sx(c[M-1:0]) - sx(a[M-1:0])) * (sx(b[2*M-1:M]) - sx(a[2*M-1:M]));
      if (area <= 0) begin
         m_cull++;
         return;
      end
`endif
      m_emit++;
      sb.push_back({c, b, a});
   endtask

   task automatic model_beat(input logic [M-1:0] d, input bit last, input bit mode);
      int n;
      if (m_idx == 0 && mesh.size() == 0) m_mode = mode;
      if (last && m_idx != 3) begin
         m_perr = 1'b1;
         m_idx  = 0;
         mesh.delete();
         return;
      end
      if (m_idx < 3) begin
         part[m_idx] = d;
         m_idx++;
         return;
      end
      m_idx = 0;
      mesh.push_back({part[2], part[1], part[0]});
      n = mesh.size();
      if (!m_mode && (n % 3) == 0)
         make_tri(mesh[n-3], mesh[n-2], mesh[n-1]);
      else if (m_mode && n >= 3) begin
         if (((n - 3) % 2) == 1) make_tri(mesh[n-3], mesh[n-1], mesh[n-2]);
         else                    make_tri(mesh[n-3], mesh[n-2], mesh[n-1]);
      end
      if (last) mesh.delete();
   endtask

   task automatic model_reset();
      mesh.delete();
      sb.delete();
      m_idx  = 0;
      m_emit = 0;
      m_cull = 0;
      m_perr = 1'b0;
   endtask

   // called just after a falling edge; inputs already driven for this cycle
   task automatic step();
      bit acc;
      check_eq("proto_err", proto_err, m_perr);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check_eq("spurious_tri", out_valid, 1'b0);
         end else begin
            check_eq("tri", out_tri, sb[0]);
            check_eq("tri_count", tri_count, CNT_W'(m_emit - sb.size()));
            check_eq("cull_count", cull_count, CNT_W'(m_cull));
            void'(sb.pop_front());
         end
      end
      if (acc) model_beat(in_data, in_last, mode_strip);
      beat_acc = acc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_beat(input int d, input bit last);
      in_valid = 1'b1;
      in_data  = M'(d);
      in_last  = last;
      beat_acc = 1'b0;
      for (int t = 0; t < 200 && !beat_acc; t++) step();
      if (!beat_acc) check_eq("beat_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_vert(input int x, input int y, input int z, input bit last);
      send_beat(x, 1'b0);
      send_beat(y, 1'b0);
      send_beat(z, 1'b0);
      send_beat(256, last);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      int verts;
      int cyc;
      bit was_w;

      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", in_ready, 1'b0);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_tri", out_tri, '0);
      check_eq("rst_tri_count", tri_count, '0);
      check_eq("rst_cull_count", cull_count, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("in_ready_after_rst", in_ready, 1'b1);

      // single list triangle with latency check
      mode_strip = 1'b0;
      send_vert(0, 0, 1, 1'b0);
      send_vert(10, 0, 1, 1'b0);
      send_vert(0, 10, 1, 1'b1);
      check_eq("lat_eval", out_valid, 1'b0);
      step();
      check_eq("lat_hold", out_valid, 1'b1);
      check_eq("t1_x0", out_tri[M-1:0], '0);
      check_eq("t1_x1", out_tri[4*M-1:3*M], 10);
      check_eq("t1_y2", out_tri[8*M-1:7*M], 10);
      idle(3);
      check_eq("t1_tri_count", tri_count, 1);

      // strip of 5 vertices -> 3 triangles
      mode_strip = 1'b1;
      send_vert(0, 0, 2, 1'b0);
      send_vert(10, 0, 3, 1'b0);
      send_vert(0, 10, 4, 1'b0);
      send_vert(10, 10, 5, 1'b0);
      send_vert(0, 20, 6, 1'b1);
      idle(6);
      check_eq("strip_tri_count", tri_count, 4);
      check_eq("strip_drained", sb.size(), 0);

      // output backpressure with a pending input beat
      mode_strip = 1'b0;
      out_ready  = 1'b0;
      send_vert(0, 0, 7, 1'b0);
      send_vert(10, 0, 7, 1'b0);
      send_vert(0, 10, 7, 1'b0);
      in_valid = 1'b1;
      in_data  = M'(1);
      repeat (20) step();
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_out_valid", out_valid, 1'b1);
      if (sb.size() != 0) check_eq("bp_out_tri", out_tri, sb[0]);
      out_ready = 1'b1;
      send_vert(1, 2, 3, 1'b0);
      send_vert(21, 2, 3, 1'b0);
      send_vert(1, 22, 3, 1'b1);
      idle(6);
      check_eq("bp_tri_count", tri_count, 6);

      // in_last on the y beat
      send_beat(5, 1'b0);
      send_beat(6, 1'b1);
      idle(2);
      check_eq("perr_set", proto_err, 1'b1);
      send_vert(0, 0, 9, 1'b0);
      send_vert(10, 0, 9, 1'b0);
      send_vert(0, 10, 9, 1'b1);
      idle(6);
      check_eq("perr_tri_count", tri_count, 7);

      // cull cases: CW, degenerate, then CCW
      send_vert(0, 0, 1, 1'b0);
      send_vert(0, 10, 1, 1'b0);
      send_vert(10, 0, 1, 1'b1);
      send_vert(0, 0, 1, 1'b0);
      send_vert(5, 5, 1, 1'b0);
      send_vert(10, 10, 1, 1'b1);
      send_vert(0, 0, 1, 1'b0);
      send_vert(10, 0, 1, 1'b0);
      send_vert(0, 10, 1, 1'b1);
      idle(6);
`ifdef BACKFACE_CULL_EN
      check_eq("cull_count_dir", cull_count, 2);
      check_eq("cull_tri_count", tri_count, 8);
`else
      check_eq("cull_count_dir", cull_count, 0);
      check_eq("cull_tri_count", tri_count, 10);
`endif

      // randomized traffic with a reset pulse mid-mesh
      verts = 0;
      cyc   = 0;
      while (verts < 1000 && cyc < 20000) begin
         if (cyc == 3000) begin
            rst_n = 1'b0;
            model_reset();
            in_valid = 1'b0;
            #1;
            check_eq("mid_rst_out_valid", out_valid, 1'b0);
            check_eq("mid_rst_tri_count", tri_count, '0);
            step();
            step();
            rst_n = 1'b1;
         end
         in_valid  = ($urandom % 10) < 7;
         out_ready = ($urandom % 10) < 7;
         in_data   = M'($urandom);
         in_last   = (m_idx == 3) ? (($urandom % 8) == 0) : (($urandom % 64) == 0);
         was_w     = (m_idx == 3);
         step();
         if (beat_acc && was_w) begin
            verts++;
            if (in_last) mode_strip = ($urandom % 2) == 1;
         end
         cyc++;
      end
      check_eq("rand_vert_budget", verts >= 1000, 1'b1);
      out_ready = 1'b1;
      idle(10);
      check_eq("final_drained", sb.size(), 0);
      check_eq("final_tri_count", tri_count, CNT_W'(m_emit));
      check_eq("final_cull_count", cull_count, CNT_W'(m_cull));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
